// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and line-field helpers for the direct-mapped
// write-back data cache (dcache_wb_direct and dcache_line_array).
//   - state_e    : controller states
//   - widths     : word/line/address geometry (4 words of 32 bits per line)
//   - line_word  : extract one 32-bit word from a 128-bit line
//   - line_merge : replace one 32-bit word inside a 128-bit line
package dcache_pkg;

  localparam int unsigned ADDR_W     = 30;  // word address width
  localparam int unsigned BLK_ADDR_W = 28;  // block address width (ADDR_W - OFF_W)
  localparam int unsigned OFF_W      = 2;   // word offset within a line
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned LINE_W     = 128;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

  // Word 0 lives in bits [31:0] of a line.
  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [OFF_W-1:0]  off);
    return line[{off, 5'd0} +: WORD_W];
  endfunction

  function automatic logic [LINE_W-1:0] line_merge(input logic [LINE_W-1:0] line,
                                                   input logic [OFF_W-1:0]  off,
                                                   input logic [WORD_W-1:0] word);
    logic [LINE_W-1:0] r;
    r = line;
    r[{off, 5'd0} +: WORD_W] = word;
    return r;
  endfunction

endpackage

// File: rtl/dcache_line_array.sv
// dcache_line_array: valid/dirty/tag/data storage for the direct-mapped cache.
// Ports:
//   clk, rst_n      clock, async active-low reset (clears valid/dirty only)
//   i_idx           line index for both the read port and the write ports
//   i_fill_en       full-line refill: tag + data written, valid=1, dirty=0
//   i_fill_tag/line refill tag and line contents
//   i_store_en      single-word store into the indexed line, dirty=1
//   i_store_off/word store word offset and data
//   i_clr_dirty     victim written back, dirty=0
//   o_valid/o_dirty/o_tag/o_line  combinational read of the indexed line
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_BLOCKS = 8,
  parameter int unsigned IDX_W      = 3,
  parameter int unsigned TAG_W      = 25
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic              i_fill_en,
  input  logic [TAG_W-1:0]  i_fill_tag,
  input  logic [LINE_W-1:0] i_fill_line,
  input  logic              i_store_en,
  input  logic [OFF_W-1:0]  i_store_off,
  input  logic [WORD_W-1:0] i_store_word,
  input  logic              i_clr_dirty,
  output logic              o_valid,
  output logic              o_dirty,
  output logic [TAG_W-1:0]  o_tag,
  output logic [LINE_W-1:0] o_line
);

  logic [NUM_BLOCKS-1:0] r_valid;
  logic [NUM_BLOCKS-1:0] r_dirty;
  logic [TAG_W-1:0]      r_tag  [NUM_BLOCKS];
  logic [LINE_W-1:0]     r_data [NUM_BLOCKS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (i_fill_en) begin
        r_valid[i_idx] <= 1'b1;
        r_dirty[i_idx] <= 1'b0;
      end else if (i_store_en) begin
        r_dirty[i_idx] <= 1'b1;
      end else if (i_clr_dirty) begin
        r_dirty[i_idx] <= 1'b0;
      end
    end
  end

  // Tag/data are not reset; valid gates their use.
  always_ff @(posedge clk) begin
    if (i_fill_en) begin
      r_tag[i_idx]  <= i_fill_tag;
      r_data[i_idx] <= i_fill_line;
    end else if (i_store_en) begin
      r_data[i_idx] <= line_merge(r_data[i_idx], i_store_off, i_store_word);
    end
  end

  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_line  = r_data[i_idx];

endmodule

// File: rtl/dcache_wb_direct.sv
// dcache_wb_direct: write-back, write-allocate, direct-mapped data cache.
// Hits complete combinationally; misses stall the pipeline while a dirty
// victim is written back (WRITEBACK) and the line is refilled (ALLOCATE).
// Ports:
//   clk, rst_n              clock, async active-low reset
//   proc_ren/proc_wen       load/store request (store wins if both set)
//   proc_addr/proc_wdata    word address {tag,idx,off}, store data
//   proc_stall/proc_rdata   hold request / load data
//   mem_read/mem_write      block read/write request (Moore, exclusive)
//   mem_addr/mem_wdata      block address, victim line
//   mem_ready/mem_rdata     memory done, refill line
module dcache_wb_direct
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_BLOCKS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  proc_ren,
  input  logic                  proc_wen,
  input  logic [ADDR_W-1:0]     proc_addr,
  input  logic [WORD_W-1:0]     proc_wdata,
  output logic                  proc_stall,
  output logic [WORD_W-1:0]     proc_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [BLK_ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0]     mem_wdata,
  input  logic                  mem_ready,
  input  logic [LINE_W-1:0]     mem_rdata
);

  localparam int unsigned IDX_W = $clog2(NUM_BLOCKS);
  localparam int unsigned TAG_W = BLK_ADDR_W - IDX_W;

  state_e r_state;
  state_e w_next;

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [OFF_W-1:0]  w_off;
  logic              w_valid;
  logic              w_dirty;
  logic [TAG_W-1:0]  w_line_tag;
  logic [LINE_W-1:0] w_line;
  logic              w_hit;
  logic              w_req;
  logic              w_store_en;
  logic              w_fill_en;
  logic              w_clr_dirty;

  assign w_off = proc_addr[OFF_W-1:0];
  assign w_idx = proc_addr[OFF_W +: IDX_W];
  assign w_tag = proc_addr[ADDR_W-1 -: TAG_W];

  assign w_hit      = w_valid && (w_line_tag == w_tag);
  assign w_req      = proc_ren || proc_wen;
  assign w_store_en = (r_state == IDLE) && proc_wen && w_hit;
  assign proc_rdata = line_word(w_line, w_off);

  dcache_line_array #(
    .NUM_BLOCKS (NUM_BLOCKS),
    .IDX_W      (IDX_W),
    .TAG_W      (TAG_W)
  ) u_lines (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_idx        (w_idx),
    .i_fill_en    (w_fill_en),
    .i_fill_tag   (w_tag),
    .i_fill_line  (mem_rdata),
    .i_store_en   (w_store_en),
    .i_store_off  (w_off),
    .i_store_word (proc_wdata),
    .i_clr_dirty  (w_clr_dirty),
    .o_valid      (w_valid),
    .o_dirty      (w_dirty),
    .o_tag        (w_line_tag),
    .o_line       (w_line)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Memory-side outputs depend on state only, so reset drops them at once.
  always_comb begin
    w_next      = r_state;
    proc_stall  = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    w_fill_en   = 1'b0;
    w_clr_dirty = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_req && !w_hit) begin
          proc_stall = 1'b1;
          w_next     = w_dirty ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        proc_stall = 1'b1;
        mem_write  = 1'b1;
        mem_addr   = {w_line_tag, w_idx};
        mem_wdata  = w_line;
        if (mem_ready) begin
          w_clr_dirty = 1'b1;
          w_next      = ALLOCATE;
        end
      end
      ALLOCATE: begin
        proc_stall = 1'b1;
        mem_read   = 1'b1;
        mem_addr   = proc_addr[ADDR_W-1:OFF_W];
        if (mem_ready) begin
          w_fill_en = 1'b1;
          w_next    = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_wb_direct.sv
module tb_dcache_wb_direct;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         proc_ren = 1'b0;
  logic         proc_wen = 1'b0;
  logic [29:0]  proc_addr = '0;
  logic [31:0]  proc_wdata = '0;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ready = 1'b0;
  logic [127:0] mem_rdata = '0;

  always #5 clk = ~clk;

  dcache_wb_direct #(
    .NUM_BLOCKS (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .proc_ren   (proc_ren),
    .proc_wen   (proc_wen),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_stall (proc_stall),
    .proc_rdata (proc_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  bit          both_seen = 1'b0;

  // Backing memory seen by the cache, and a flat golden word memory.
  logic [127:0] bmem [int unsigned];
  logic [31:0]  gold [int unsigned];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] def_word(input logic [29:0] wa);
    return {8'hA5, 2'b00, wa[21:0]};
  endfunction

  function automatic logic [127:0] mem_line(input logic [27:0] ba);
    if (bmem.exists(int'(ba))) return bmem[int'(ba)];
    return {def_word({ba, 2'd3}), def_word({ba, 2'd2}), def_word({ba, 2'd1}), def_word({ba, 2'd0})};
  endfunction

  function automatic logic [31:0] gold_word(input logic [29:0] a);
    if (gold.exists(int'(a))) return gold[int'(a)];
    return def_word(a);
  endfunction

  // One request held until stall drops; memory answers after lat cycles of each phase.
  task automatic access(input logic ren, input logic wen, input logic [29:0] addr,
                        input logic [31:0] wdata, input int unsigned lat,
                        output logic [31:0] rdata, output int unsigned cycles,
                        output logic wb_seen, output logic [27:0] wb_addr,
                        output logic [127:0] wb_data, output logic al_seen,
                        output logic [27:0] al_addr);
    int unsigned cnt;
    int unsigned ph;
    int unsigned prev_ph;
    bit done;
    rdata = '0; cycles = 0; wb_seen = 1'b0; wb_addr = '0; wb_data = '0;
    al_seen = 1'b0; al_addr = '0;
    cnt = 0; prev_ph = 0; done = 1'b0;
    @(posedge clk); #1;
    proc_ren = ren; proc_wen = wen; proc_addr = addr; proc_wdata = wdata;
    for (int unsigned i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (mem_read && mem_write) both_seen = 1'b1;
      if (!proc_stall) begin
        rdata = proc_rdata;
        done  = 1'b1;
      end else begin
        cycles++;
        ph = mem_write ? 1 : (mem_read ? 2 : 0);
        if (ph != prev_ph) cnt = 0;
        prev_ph = ph;
        if (ph == 1 && !wb_seen) begin wb_seen = 1'b1; wb_addr = mem_addr; wb_data = mem_wdata; end
        if (ph == 2 && !al_seen) begin al_seen = 1'b1; al_addr = mem_addr; end
        if (ph != 0) begin
          cnt++;
          if (cnt == lat) begin
            mem_ready = 1'b1;
            if (ph == 1) bmem[int'(mem_addr)] = mem_wdata;
            else         mem_rdata = mem_line(mem_addr);
          end
        end
      end
    end
    if (!done) check("access_timeout", 1'b0, 1'b1);
    else if (wen) gold[int'(addr)] = wdata;
  endtask

  logic [31:0]  rd;
  int unsigned  cyc;
  logic         wbs, als;
  logic [27:0]  wba, ala;
  logic [127:0] wbd;

  initial begin
    // Test 1 line contents for block 4.
    bmem[4] = 128'hDDCCBB03_DDCCBB02_DDCCBB01_DDCCBBAA;
    gold[32'h10] = 32'hDDCCBBAA; gold[32'h11] = 32'hDDCCBB01;
    gold[32'h12] = 32'hDDCCBB02; gold[32'h13] = 32'hDDCCBB03;

    repeat (2) @(negedge clk);
    check("rst_stall", proc_stall, 1'b0);
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_mem_write", mem_write, 1'b0);
    check("rst_mem_addr", mem_addr, 28'h0);
    check("rst_mem_wdata", mem_wdata, 128'h0);
    rst_n = 1'b1;

    // 1: clean miss, latency 3
    access(1, 0, 30'h10, 0, 3, rd, cyc, wbs, wba, wbd, als, ala);
    check("t1_cycles", cyc, 4);
    check("t1_no_wb", wbs, 1'b0);
    check("t1_al_addr", ala, 28'h4);
    check("t1_rdata", rd, 32'hDDCCBBAA);

    // 2: store hit then load back
    access(0, 1, 30'h11, 32'hCAFEF00D, 1, rd, cyc, wbs, wba, wbd, als, ala);
    check("t2_store_cycles", cyc, 0);
    access(1, 0, 30'h11, 0, 1, rd, cyc, wbs, wba, wbd, als, ala);
    check("t2_load_cycles", cyc, 0);
    check("t2_rdata", rd, 32'hCAFEF00D);

    // 3: dirty miss on idx 4
    access(1, 0, 30'h31, 0, 2, rd, cyc, wbs, wba, wbd, als, ala);
    check("t3_cycles", cyc, 5);
    check("t3_wb_addr", wba, 28'h4);
    check("t3_wb_data", wbd, 128'hDDCCBB03_DDCCBB02_CAFEF00D_DDCCBBAA);
    check("t3_al_addr", ala, 28'hC);
    check("t3_rdata", rd, 32'hA5000031);

    // 4: store miss to clean idx 2, then eviction carries merged word
    access(0, 1, 30'h48, 32'h12345678, 1, rd, cyc, wbs, wba, wbd, als, ala);
    check("t4_store_cycles", cyc, 2);
    check("t4_store_no_wb", wbs, 1'b0);
    access(1, 0, 30'h48, 0, 1, rd, cyc, wbs, wba, wbd, als, ala);
    check("t4_merged", rd, 32'h12345678);
    access(1, 0, 30'h49, 0, 1, rd, cyc, wbs, wba, wbd, als, ala);
    check("t4_neighbour", rd, 32'hA5000049);
    access(1, 0, 30'h88, 0, 1, rd, cyc, wbs, wba, wbd, als, ala);
    check("t4_evict_cycles", cyc, 3);
    check("t4_evict_addr", wba, 28'h12);
    check("t4_evict_data", wbd, 128'hA500004B_A500004A_A5000049_12345678);
    check("t4_rdata", rd, 32'hA5000088);

    // 5: reset mid-ALLOCATE
    access(1, 0, 30'h20, 0, 1, rd, cyc, wbs, wba, wbd, als, ala);
    check("t5_fill_cycles", cyc, 2);
    access(1, 0, 30'h20, 0, 1, rd, cyc, wbs, wba, wbd, als, ala);
    check("t5_hit_cycles", cyc, 0);
    @(posedge clk); #1;
    proc_ren = 1'b1; proc_wen = 1'b0; proc_addr = 30'h40;
    @(negedge clk);
    check("t5_miss_stall", proc_stall, 1'b1);
    @(negedge clk);
    check("t5_alloc_read", mem_read, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_read_drop", mem_read, 1'b0);
    check("t5_rst_addr_drop", mem_addr, 28'h0);
    proc_ren = 1'b0;
    #1;
    check("t5_rst_stall", proc_stall, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    access(1, 0, 30'h20, 0, 1, rd, cyc, wbs, wba, wbd, als, ala);
    check("t5_post_rst_miss", cyc, 2);
    check("t5_post_rst_al", ala, 28'h8);
    check("t5_post_rst_rdata", rd, 32'hA5000020);

    // 6: ren and wen together on a hit act as a store
    access(1, 1, 30'h20, 32'h0BADBEEF, 1, rd, cyc, wbs, wba, wbd, als, ala);
    check("t6_cycles", cyc, 0);
    access(1, 0, 30'h20, 0, 1, rd, cyc, wbs, wba, wbd, als, ala);
    check("t6_rdata", rd, 32'h0BADBEEF);

    // Sweep all indices at latency 1 and 10
    for (int p = 0; p < 2; p++) begin
      int unsigned lat;
      logic [24:0] ta, tb;
      logic [29:0] a;
      lat = (p == 0) ? 1 : 10;
      ta  = (p == 0) ? 25'd5 : 25'd7;
      tb  = (p == 0) ? 25'd6 : 25'd8;
      for (int i = 0; i < 8; i++) begin
        a = {ta, 3'(i), 2'(i)};
        access(0, 1, a, 32'h50000000 | (p << 8) | i, lat, rd, cyc, wbs, wba, wbd, als, ala);
      end
      for (int i = 0; i < 8; i++) begin
        a = {tb, 3'(i), 2'(i)};
        access(1, 0, a, 0, lat, rd, cyc, wbs, wba, wbd, als, ala);
        check($sformatf("sw%0d_dirty_cycles_%0d", p, i), cyc, 2 * lat + 1);
        check($sformatf("sw%0d_wb_addr_%0d", p, i), wba, {ta, 3'(i)});
        check($sformatf("sw%0d_rdata_%0d", p, i), rd, gold_word(a));
      end
      for (int i = 0; i < 8; i++) begin
        a = {ta, 3'(i), 2'(i)};
        access(1, 0, a, 0, lat, rd, cyc, wbs, wba, wbd, als, ala);
        check($sformatf("sw%0d_clean_cycles_%0d", p, i), cyc, lat + 1);
        check($sformatf("sw%0d_readback_%0d", p, i), rd, 32'h50000000 | (p << 8) | i);
      end
    end

    check("rw_exclusive", both_seen, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
